imem_dmem_arbiter: RTL

- Shares one single-ported memory bus between the fetch stage (instruction requester) and the load/store unit (data requester).
- Both requesters and the memory use the same valid/ready handshake as the fetch-stage memory interface: a transfer completes in the cycle valid and ready are both high, and rdata is valid in that cycle.
- Data requests have priority by default. An optional starvation guard bounds how long fetch can be locked out.
- The arbiter holds ownership across multi-cycle memory stalls. It drains fetch requests that are abandoned (redirects) so the memory never sees valid withdrawn mid-transfer.

---
 rtl/imem_dmem_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-ported valid/ready memory bus between
// the fetch stage (instr) and the load/store unit (data).
// Data has priority by default. Abandoned fetches are drained so the memory
// never sees valid withdrawn mid-transfer.
// Optional build macro ARB_STARVE_GUARD_EN adds a starvation guard. After
// STARVE_LIMIT consecutive data grants while fetch waits, the next idle pick
// goes to fetch.

`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

module imem_dmem_arbiter #(
    parameter int ADDR_W       = `RISCV_ADDR_WIDTH,
    parameter int DATA_W       = `RISCV_WORD_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // fetch requester
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [ADDR_W-1:0] instr_addr_i,
    output logic [DATA_W-1:0] instr_rdata_o,
    // load/store requester
    input  logic              data_valid_i,
    output logic              data_ready_o,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    input  logic [3:0]        data_we_i,
    output logic [DATA_W-1:0] data_rdata_o,
    // shared memory bus
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [3:0]        mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    // current bus owner: 00 none, 01 instr, 10 data
    output logic [1:0]        grant_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam logic [1:0] GRANT_NONE  = 2'b00;
    localparam logic [1:0] GRANT_INSTR = 2'b01;
    localparam logic [1:0] GRANT_DATA  = 2'b10;

    // Reject an out-of-range limit at elaboration time.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("imem_dmem_arbiter: STARVE_LIMIT must be in 1..255");
    end

    state_t            state;
    logic [ADDR_W-1:0] addr_q;     // last fetch address seen while fetch owned the bus
    logic              prefer_i;   // guard forces fetch to win the next idle pick
    logic              pick_i;
    logic              pick_d;

    // Read data is a plain pass-through; each requester qualifies it with its ready.
    assign instr_rdata_o = mem_rdata_i;
    assign data_rdata_o  = mem_rdata_i;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [7:0] LIMIT_C = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt;

    assign prefer_i = instr_valid_i && (starve_cnt >= LIMIT_C);

    // Count data wins while fetch is waiting; any fetch completion or a dropped fetch clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 8'd0;
        end else if (!instr_valid_i) begin
            starve_cnt <= 8'd0;
        end else if (instr_ready_o || (state == DRAIN && mem_ready_i)) begin
            starve_cnt <= 8'd0;
        end else if (data_ready_o && starve_cnt != 8'hFF) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
`else
    assign prefer_i = 1'b0;
`endif

    // Idle pick: data first unless the guard is holding the door open for fetch.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        pick_d = 1'b0;
        pick_i = 1'b0;
        if (state == IDLE) begin
            if (data_valid_i && !prefer_i) begin
                pick_d = 1'b1;
            end else if (instr_valid_i) begin
                pick_i = 1'b1;
            end
        end
    end

    // Route the owner onto the memory bus; everything is forced quiet while rst is high.
    always_comb begin
        mem_valid_o   = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        mem_we_o      = 4'd0;
        instr_ready_o = 1'b0;
        data_ready_o  = 1'b0;
        grant_o       = GRANT_NONE;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        mem_valid_o  = 1'b1;
                        mem_addr_o   = data_addr_i;
                        mem_wdata_o  = data_wdata_i;
                        mem_we_o     = data_we_i;
                        data_ready_o = mem_ready_i;
                        grant_o      = GRANT_DATA;
                    end else if (pick_i) begin
                        mem_valid_o   = 1'b1;
                        mem_addr_o    = instr_addr_i;
                        instr_ready_o = mem_ready_i;
                        grant_o       = GRANT_INSTR;
                    end
                end
                BUSY_D: begin
                    mem_valid_o  = 1'b1;
                    mem_addr_o   = data_addr_i;
                    mem_wdata_o  = data_wdata_i;
                    mem_we_o     = data_we_i;
                    data_ready_o = mem_ready_i;
                    grant_o      = GRANT_DATA;
                end
                BUSY_I: begin
                    // A fetch dropped this cycle keeps its captured address on the bus.
                    mem_valid_o = 1'b1;
                    grant_o     = GRANT_INSTR;
                    if (instr_valid_i) begin
                        mem_addr_o    = instr_addr_i;
                        instr_ready_o = mem_ready_i;
                    end else begin
                        mem_addr_o = addr_q;
                    end
                end
                DRAIN: begin
                    // Finish the abandoned fetch; its response is thrown away.
                    mem_valid_o = 1'b1;
                    mem_addr_o  = addr_q;
                    grant_o     = GRANT_INSTR;
                end
                default: ;
            endcase
        end
    end

    // Ownership FSM: hold the owner across memory stalls, drain dropped fetches.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d && !mem_ready_i) begin
                        state <= BUSY_D;
                    end else if (pick_i && !mem_ready_i) begin
                        state <= BUSY_I;
                    end
                end
                BUSY_D: begin
                    if (mem_ready_i) begin
                        state <= IDLE;
                    end
                end
                BUSY_I: begin
                    if (mem_ready_i) begin
                        state <= IDLE;
                    end else if (!instr_valid_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Track the fetch address whenever fetch holds the bus with a live request.
    always_ff @(posedge clk) begin
        // NOTE: addr_q is pure datapath with no reset; it is always loaded when fetch wins, before BUSY_I/DRAIN can read it.
        if ((pick_i && !rst) || (state == BUSY_I && instr_valid_i)) begin
            addr_q <= instr_addr_i;
        end
    end

endmodule
